serial_to_parallel_loader: RTL and testbench
============================================

Name: serial_to_parallel_loader

Overview:
- Upstream feeder for the team's parallel-load registers.
- Assembles a serial bit stream into WIDTH-bit words.
- Presents each completed word on dout with a one-cycle load strobe, which connects directly to a downstream register's d/load pins.
- Supports gapped input (valid-qualified bits) and frame resynchronisation.

Parameters:
- WIDTH, 4, data word width in bits. Legal range is 2 to 32.
- MSB_FIRST, 1, bit order. 1 means the first received bit is dout[WIDTH-1]. 0 means the first received bit is dout[0].

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sin_valid  input  1  sin_data holds a valid bit this cycle.
- sin_data  input  1  serial data bit.
- sync  input  1  start-of-frame marker. It marks the current valid bit as bit 0 of a new word.
- dout  output  WIDTH  last completed word. It is held stable between strobes.
- load  output  1  one-cycle strobe meaning dout has just been updated.
- busy  output  1  a partial word is in progress.
- frame_err  output  1  one-cycle pulse when a partial word is discarded by sync.
- parity_err  output  1  one-cycle pulse when a word fails the parity check. See Optional Feature.

Behaviour:
- Reset is synchronous and active-high, clock is clk. On reset:
  - The shift register, bit counter, dout, load, busy, frame_err and parity_err all clear to 0.
  - The FSM enters IDLE.
- Reset asserted mid-word discards the partial word. It produces no load and no frame_err.
- FSM states:
  - IDLE (count==0). sin_valid=1 captures a bit, sets count=1 and moves to SHIFT.
  - SHIFT. Each sin_valid=1 captures one bit and increments count. Cycles with sin_valid=0 hold all state, so gaps of any length are allowed.
  - Word completion: a sin_valid when count==WIDTH-1 completes the word. At that same clock edge, dout takes the full assembled word (including the final bit), load=1 and count=0, and the FSM returns to IDLE.
- Latency: load is high in the cycle immediately after the edge that sampled the final bit.
- load is exactly one cycle wide. load is registered, not combinational from sin_*.
- Back-to-back words with sin_valid held high produce load every WIDTH cycles with no bubble.
- dout changes only on a load edge (or on reset). Otherwise it holds its value indefinitely.
- busy = (count != 0) and is registered.
- sync rules:
  - sync=1 with sin_valid=1: the current bit becomes bit 0 of a new word and count becomes 1. If count was non-zero beforehand, the partial word is dropped and frame_err pulses for one cycle.
  - sync=1 with sin_valid=0: count becomes 0 and the FSM goes to IDLE. frame_err pulses only if count was non-zero.
  - sync when count==WIDTH-1 with sin_valid=1: the sync wins. No load is produced and frame_err=1.
- Inputs are assumed synchronous to clk. No CDC logic is inside this block.

Optional Feature:
- Macro name: SERIAL_PARITY_CHECK_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit, so the data bits plus the parity bit XOR to 0.
  - count runs to WIDTH, and the parity bit is the completing bit.
  - Match: dout updates and load pulses, with the same latency relative to the parity-bit edge.
  - Mismatch: dout holds, load stays 0, and parity_err pulses for one cycle.
  - sync handling is unchanged, with the parity bit counting as a frame position.
- Undefined:
  - No parity bit; frames are WIDTH bits.
  - The parity_err port is still present and tied to 0.

Test Plan (WIDTH=4, MSB_FIRST=1 unless stated):
1. Reset, then sin_valid=1 continuously with bits 1,0,1,1 → load=1 for one cycle after the 4th bit edge, dout=4'b1011, busy 1→0. dout then holds 4'b1011 with no further valid input.
2. Same bits with sin_valid gaps of 0–3 cycles between them → identical dout=4'b1011 and a single load pulse.
3. 8 bits back-to-back (1,1,0,0,0,1,1,0) → two loads exactly 4 cycles apart, dout=4'b1100 then 4'b0110. Repeat with MSB_FIRST=0 → dout=4'b0011 then 4'b0110.
4. Send 2 bits, then sync with sin_valid and bits 0,1,1,1 → frame_err pulses once at the sync edge, then load with dout=4'b0111. Also: reset after 3 bits, then 4 new bits → no load before the new word.
5. With SERIAL_PARITY_CHECK_EN defined, send 1,0,1,1 then parity 1 → load with dout=4'b1011. Send 1,0,1,1 then parity 0 → parity_err pulses once, load=0, dout unchanged.

Source files
------------

// File: rtl/serial_to_parallel_loader.sv
// Serial-to-parallel word assembler with valid-qualified bits, sync resync and a registered load strobe.
// Optional even-parity trailer bit per frame when SERIAL_PARITY_CHECK_EN is defined.
module serial_to_parallel_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             load,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

`ifdef SERIAL_PARITY_CHECK_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] shifted;
`ifdef SERIAL_PARITY_CHECK_EN
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sr_d        = sr_q;
    dout_d      = dout_q;
    load_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif
    // MSB-first shifts toward the top so the first bit ends in dout[WIDTH-1].
    if (MSB_FIRST) shifted = {sr_q[WIDTH-2:0], sin_data};
    else           shifted = {sin_data, sr_q[WIDTH-1:1]};

    if (sync) begin
      frame_err_d = (count_q != '0);
      if (sin_valid) begin
        sr_d    = shifted;
        count_d = CW'(1);
        state_d = ST_SHIFT;
      end else begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    end else if (sin_valid) begin
      case (state_q)
        ST_IDLE: begin
          sr_d    = shifted;
          count_d = CW'(1);
          state_d = ST_SHIFT;
        end
        default: begin
          if (count_q == LAST) begin
            count_d = '0;
            state_d = ST_IDLE;
`ifdef SERIAL_PARITY_CHECK_EN
            // Completing bit is the parity trailer; data already sits in sr_q.
            if ((^sr_q ^ sin_data) == 1'b0) begin
              dout_d = sr_q;
              load_d = 1'b1;
            end else begin
              parity_err_d = 1'b1;
            end
`else
            dout_d = shifted;
            load_d = 1'b1;
`endif
          end else begin
            sr_d    = shifted;
            count_d = count_q + CW'(1);
          end
        end
      endcase
    end
    busy_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      sr_q        <= '0;
      dout_q      <= '0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sr_q        <= sr_d;
      dout_q      <= dout_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
`ifdef SERIAL_PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
`ifdef SERIAL_PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel_loader.sv
// Bench for serial_to_parallel_loader: directed vector table, gap/parity sequences and
// randomized traffic against a bit-queue reference model; MSB-first and LSB-first instances.
module tb_serial_to_parallel_loader;
  localparam int W = 4;
`ifdef SERIAL_PARITY_CHECK_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk = 1'b0;
  logic reset, sin_valid, sin_data, sync;
  logic [W-1:0] dout_m, dout_l;
  logic load_m, busy_m, fe_m, pe_m;
  logic load_l, busy_l, fe_l, pe_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_to_parallel_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin_data(sin_data), .sync(sync),
    .dout(dout_m), .load(load_m), .busy(busy_m), .frame_err(fe_m), .parity_err(pe_m)
  );

  serial_to_parallel_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin_data(sin_data), .sync(sync),
    .dout(dout_l), .load(load_l), .busy(busy_l), .frame_err(fe_l), .parity_err(pe_l)
  );

  // Reference model: the bits of the frame in progress, in arrival order.
  logic         mq[$];
  logic [W-1:0] m_dout_m, m_dout_l;
  logic         m_load, m_fe, m_pe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic v, input logic d, input logic s, input logic r);
    logic par;
    m_load = 1'b0;
    m_fe   = 1'b0;
    m_pe   = 1'b0;
    if (r) begin
      mq.delete();
      m_dout_m = '0;
      m_dout_l = '0;
    end else if (s) begin
      m_fe = (mq.size() != 0);
      mq.delete();
      if (v) mq.push_back(d);
    end else if (v) begin
      mq.push_back(d);
      if (mq.size() == FRAME) begin
        par = 1'b0;
        foreach (mq[i]) par ^= mq[i];
`ifdef SERIAL_PARITY_CHECK_EN
        if (par == 1'b0) m_load = 1'b1;
        else             m_pe = 1'b1;
`else
        m_load = 1'b1;
`endif
        if (m_load) begin
          for (int i = 0; i < W; i++) begin
            m_dout_m[W-1-i] = mq[i];
            m_dout_l[i]     = mq[i];
          end
        end
        mq.delete();
      end
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, sample #1 later.
  task automatic cycle(input logic v, input logic d, input logic s, input logic r);
    reset = r; sin_valid = v; sin_data = d; sync = s;
    @(posedge clk);
    model_step(v, d, s, r);
    #1;
    chk("msb_load", {31'd0, load_m}, {31'd0, m_load});
    chk("msb_dout", {28'd0, dout_m}, {28'd0, m_dout_m});
    chk("msb_busy", {31'd0, busy_m}, {31'd0, mq.size() != 0});
    chk("msb_frame_err", {31'd0, fe_m}, {31'd0, m_fe});
    chk("msb_parity_err", {31'd0, pe_m}, {31'd0, m_pe});
    chk("lsb_load", {31'd0, load_l}, {31'd0, m_load});
    chk("lsb_dout", {28'd0, dout_l}, {28'd0, m_dout_l});
    chk("lsb_busy", {31'd0, busy_l}, {31'd0, mq.size() != 0});
    chk("lsb_frame_err", {31'd0, fe_l}, {31'd0, m_fe});
    chk("lsb_parity_err", {31'd0, pe_l}, {31'd0, m_pe});
  endtask

  typedef struct {
    logic v, d, s, r;
    logic ld;
    logic [W-1:0] dm, dl;
    logic bz, fe;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, d, s, r, ld, input logic [W-1:0] dm, dl, input logic bz, fe);
    vec_t e;
    e.v = v; e.d = d; e.s = s; e.r = r; e.ld = ld; e.dm = dm; e.dl = dl; e.bz = bz; e.fe = fe;
    tbl.push_back(e);
  endtask

  task automatic send_bits_gapped(input logic [7:0] bits, input int n, output int loads);
    loads = 0;
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        if (load_m) loads++;
      end
      cycle(1'b1, bits[n-1-i], 1'b0, 1'b0);
      if (load_m) loads++;
    end
    for (int g = 0; g < 3; g++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (load_m) loads++;
    end
  endtask

  initial begin
    int loads;
    reset = 1'b1; sin_valid = 1'b0; sin_data = 1'b0; sync = 1'b0;
    m_dout_m = '0; m_dout_l = '0; m_load = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifndef SERIAL_PARITY_CHECK_EN
    //   v     d     s     r     ld    dout_msb dout_lsb busy  fe
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011, 4'b1101, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b1101, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b1101, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b1101, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b1101, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b1101, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 4'b0011, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 4'b0011, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 4'b0011, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 4'b0011, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 4'b0110, 1'b0, 1'b0);
    // two bits, then sync with a new word 0,1,1,1
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0111, 4'b1110, 1'b0, 1'b0);
    // reset after three bits, then a fresh word 0,0,1,1
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b1110, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b1110, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b1110, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, 4'b1100, 1'b0, 1'b0);
    // sync without valid mid-word
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b0, 1'b0);
    // sync on the would-be final bit wins over completion
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b0001, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0001, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].r);
      chk($sformatf("tbl%0d_load", i), {31'd0, load_m}, {31'd0, tbl[i].ld});
      chk($sformatf("tbl%0d_dout_msb", i), {28'd0, dout_m}, {28'd0, tbl[i].dm});
      chk($sformatf("tbl%0d_dout_lsb", i), {28'd0, dout_l}, {28'd0, tbl[i].dl});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy_m}, {31'd0, tbl[i].bz});
      chk($sformatf("tbl%0d_frame_err", i), {31'd0, fe_m}, {31'd0, tbl[i].fe});
      chk($sformatf("tbl%0d_parity_err", i), {31'd0, pe_m}, 32'd0);
    end

    // gapped 1,0,1,1 gives one load of 4'b1011
    for (int rep = 0; rep < 4; rep++) begin
      send_bits_gapped(8'b0000_1011, 4, loads);
      chk("gap_load_count", loads, 1);
      chk("gap_dout", {28'd0, dout_m}, 32'hB);
    end
`else
    // 1,0,1,1 + good parity 1, then 1,0,1,1 + bad parity 0
    send_bits_gapped(8'b0001_0111, 5, loads);
    chk("par_ok_load_count", loads, 1);
    chk("par_ok_dout", {28'd0, dout_m}, 32'hB);
    loads = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, (i == 1 || i == 4) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      if (pe_m) loads++;
      chk("par_bad_no_load", {31'd0, load_m}, 32'd0);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    if (pe_m) loads++;
    chk("par_bad_pulse_count", loads, 1);
    chk("par_bad_dout_held", {28'd0, dout_m}, 32'hB);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic v, s, r;
      v = ($urandom_range(0, 99) < 70);
      s = ($urandom_range(0, 99) < 5);
      r = ($urandom_range(0, 199) == 0);
      cycle(v, 1'($urandom_range(0, 1)), s, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
